// File: rtl/instr_imm_sequencer.sv
// Decode-stage front end: packs a little-endian byte stream into 32-bit instructions,
// registers the immediate format select, and holds the word until the consumer accepts it.
module instr_imm_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] InstrD,
    output logic [2:0]  ImmSrcD,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        illegal,
    output logic        timeout_err
);

    localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {StCollect, StHold} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [IdleW-1:0]   idle_q, idle_d;
    logic [31:0]        instr_q, instr_d;
    logic [2:0]         imm_src_q, imm_src_d;
    logic               illegal_q, illegal_d;
    logic               timeout_err_q, timeout_err_d;

    // Returns {illegal, ImmSrcD} for a 7-bit opcode.
    function automatic logic [3:0] decode_op(input logic [6:0] op);
        logic [3:0] res;
        unique case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: res = 4'b0_000;
            7'b0110011:                                     res = 4'b0_000;
            7'b0100011:                                     res = 4'b0_001;
            7'b1100011:                                     res = 4'b0_010;
            7'b1101111:                                     res = 4'b0_011;
            7'b0110111, 7'b0010111:                         res = 4'b0_100;
            default:                                        res = 4'b1_000;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StCollect;
            cnt_q         <= 2'd0;
            idle_q        <= '0;
            instr_q       <= 32'd0;
            imm_src_q     <= 3'd0;
            illegal_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            instr_q       <= instr_d;
            imm_src_q     <= imm_src_d;
            illegal_q     <= illegal_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idle_d        = idle_q;
        instr_d       = instr_q;
        imm_src_d     = imm_src_q;
        illegal_d     = illegal_q;
        timeout_err_d = 1'b0;
        if (flush) begin
            state_d = StCollect;
            cnt_d   = 2'd0;
            idle_d  = '0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (byte_valid) begin
                        instr_d[{cnt_q, 3'b000} +: 8] = byte_in;
                        cnt_d  = cnt_q + 2'd1;
                        idle_d = '0;
                        if (cnt_q == 2'd3) begin
                            // Byte 0 already holds the opcode, so decode from the stored word.
                            state_d = StHold;
                            {illegal_d, imm_src_d} = decode_op(instr_q[6:0]);
                        end
                    end else if (TIMEOUT != 0 && cnt_q != 2'd0) begin
                        if (idle_q == IdleW'(TIMEOUT - 1)) begin
                            cnt_d         = 2'd0;
                            idle_d        = '0;
                            timeout_err_d = 1'b1;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        state_d = StCollect;
                        cnt_d   = 2'd0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        byte_ready  = (state_q == StCollect);
        instr_valid = (state_q == StHold);
        InstrD      = instr_q;
        ImmSrcD     = imm_src_q;
        illegal     = illegal_q;
        timeout_err = timeout_err_q;
    end

endmodule

// File: tb/tb_instr_imm_sequencer.sv
// Directed bench for instr_imm_sequencer with a queue-based reference model and
// per-cycle comparison, plus literal checks on hand-computed words.
module tb_instr_imm_sequencer;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] InstrD;
    logic [2:0]  ImmSrcD;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        illegal;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    instr_imm_sequencer #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .InstrD     (InstrD),
        .ImmSrcD    (ImmSrcD),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .illegal    (illegal),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: bytes of the word in progress kept in a queue.
    logic [7:0]  mq[$];
    logic [31:0] m_word = 32'd0;
    bit          m_hold = 1'b0;
    int          m_idle = 0;
    logic [2:0]  m_imm = 3'd0;
    bit          m_ill = 1'b0;
    bit          m_tout = 1'b0;

    function automatic logic [3:0] ref_decode(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73, 7'h33: return 4'b0_000;
            7'h23:                             return 4'b0_001;
            7'h63:                             return 4'b0_010;
            7'h6F:                             return 4'b0_011;
            7'h37, 7'h17:                      return 4'b0_100;
            default:                           return 4'b1_000;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [3:0] d;
        if (!rst_n) begin
            mq.delete();
            m_word = 32'd0; m_hold = 1'b0; m_idle = 0;
            m_imm = 3'd0; m_ill = 1'b0; m_tout = 1'b0;
        end else begin
            m_tout = 1'b0;
            if (flush) begin
                mq.delete();
                m_hold = 1'b0;
                m_idle = 0;
            end else if (m_hold) begin
                if (instr_ready) begin
                    m_hold = 1'b0;
                    mq.delete();
                end
            end else if (byte_valid) begin
                m_word[8*mq.size() +: 8] = byte_in;
                mq.push_back(byte_in);
                m_idle = 0;
                if (mq.size() == 4) begin
                    m_hold = 1'b1;
                    d = ref_decode(m_word[6:0]);
                    m_ill = d[3];
                    m_imm = d[2:0];
                    mq.delete();
                end
            end else if (mq.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    mq.delete();
                    m_idle = 0;
                    m_tout = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", 32'(byte_ready), 32'(!m_hold));
            chk("instr_valid", 32'(instr_valid), 32'(m_hold));
            chk("timeout_err", 32'(timeout_err), 32'(m_tout));
            if (m_hold) begin
                chk("InstrD", InstrD, m_word);
                chk("ImmSrcD", 32'(ImmSrcD), 32'(m_imm));
                chk("illegal", 32'(illegal), 32'(m_ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_in    = w[8*i +: 8];
            step();
        end
        byte_valid = 1'b0;
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic word_lit(input string name, input logic [31:0] w, input logic [2:0] imm,
                            input logic ill);
        send(w, 4);
        chk({name, "_valid"}, 32'(instr_valid), 32'd1);
        chk({name, "_instr"}, InstrD, w);
        chk({name, "_imm"}, 32'(ImmSrcD), 32'(imm));
        chk({name, "_ill"}, 32'(illegal), 32'(ill));
    endtask

    task automatic reset_lit(input string name);
        chk({name, "_instr"}, InstrD, 32'd0);
        chk({name, "_imm"}, 32'(ImmSrcD), 32'd0);
        chk({name, "_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_ready"}, 32'(byte_ready), 32'd1);
        chk({name, "_terr"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk_en = 1'b1;
        reset_lit("rst");
        rst_n = 1'b1;

        // Back-to-back word, held three cycles with instr_ready low.
        word_lit("addi", 32'h0050_0513, 3'b000, 1'b0);
        repeat (3) step();
        chk("addi_stable", InstrD, 32'h0050_0513);
        consume();
        chk("after_consume_ready", 32'(byte_ready), 32'd1);

        word_lit("sw", 32'h0051_2423, 3'b001, 1'b0);
        byte_valid = 1'b1;
        byte_in    = 8'h99;
        step();
        byte_valid = 1'b0;
        consume();
        word_lit("jal", 32'h0000_006F, 3'b011, 1'b0);
        consume();
        word_lit("beq", 32'h0000_0063, 3'b010, 1'b0);
        consume();
        word_lit("lui", 32'h0000_0037, 3'b100, 1'b0);
        consume();
        word_lit("ffff", 32'hFFFF_FFFF, 3'b000, 1'b1);
        consume();

        // Timeout after 4 idle cycles on a partial word.
        send(32'h0000_BBAA, 2);
        repeat (4) step();
        chk("tout_pulse", 32'(timeout_err), 32'd1);
        step();
        chk("tout_pulse_end", 32'(timeout_err), 32'd0);
        word_lit("post_tout", 32'h0050_0513, 3'b000, 1'b0);
        consume();

        // Byte arriving on the 4th idle cycle is accepted.
        send(32'h0000_0513, 2);
        repeat (3) step();
        send(32'h0000_0050, 2);
        chk("late_byte_valid", 32'(instr_valid), 32'd1);
        chk("late_byte_instr", InstrD, 32'h0050_0513);
        consume();

        // Flush after three bytes; byte offered with flush is dropped.
        send(32'h00EE_EEEE, 3);
        flush = 1'b1; byte_valid = 1'b1; byte_in = 8'h99;
        step();
        flush = 1'b0; byte_valid = 1'b0;
        word_lit("post_flush", 32'h0050_0513, 3'b000, 1'b0);
        consume();

        // Flush in HOLD wins over instr_ready.
        word_lit("pre_hflush", 32'h0051_2423, 3'b001, 1'b0);
        flush = 1'b1; instr_ready = 1'b1;
        step();
        flush = 1'b0; instr_ready = 1'b0;
        chk("hflush_valid", 32'(instr_valid), 32'd0);
        word_lit("post_hflush", 32'h0000_006F, 3'b011, 1'b0);
        consume();

        // Reset mid-word and mid-HOLD.
        send(32'h0000_1234, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        reset_lit("rst_word");
        word_lit("post_rst_word", 32'h0050_0513, 3'b000, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        reset_lit("rst_hold");
        word_lit("post_rst_hold", 32'h0000_0037, 3'b100, 1'b0);
        consume();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
